// File: rtl/ibert_reduce_pkg.sv
// Shared types and helpers for the streaming row max/min reducer.
// Compares are done at a fixed wide signed width so one helper serves any element width.
package ibert_reduce_pkg;

    typedef enum logic {
        RED_MAX = 1'b0,
        RED_MIN = 1'b1
    } reduce_mode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_HOLD
    } state_e;

    localparam int unsigned CMP_W = 64;

    // Most-negative w-bit two's complement value, zero-extended to CMP_W.
    function automatic logic [CMP_W-1:0] sat_neg(input int unsigned w);
        return CMP_W'(1) << (w - 1);
    endfunction

    // Most-positive w-bit two's complement value, zero-extended to CMP_W.
    function automatic logic [CMP_W-1:0] sat_pos(input int unsigned w);
        return (CMP_W'(1) << (w - 1)) - CMP_W'(1);
    endfunction

    // Strict: on equality the incumbent (earlier element) is kept.
    function automatic logic better(input logic signed [CMP_W-1:0] a,
                                    input logic signed [CMP_W-1:0] b,
                                    input reduce_mode_e            mode);
        return (mode == RED_MAX) ? (a > b) : (a < b);
    endfunction

endpackage

// File: rtl/lane_max_tree.sv
// Combinational LANES-wide masked max/min selector; the lowest lane wins ties
// because later lanes must strictly beat the current winner.
module lane_max_tree
    import ibert_reduce_pkg::*;
#(
    parameter  int unsigned D_W    = 32,
    parameter  int unsigned LANES  = 4,
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic [LANES*D_W-1:0] data,
    input  logic [LANES-1:0]     keep,
    input  reduce_mode_e         mode,
    output logic signed [D_W-1:0] win_val,
    output logic [LANE_W-1:0]    win_lane,
    output logic                 any_valid
);

    always_comb begin
        win_val   = '0;
        win_lane  = '0;
        any_valid = 1'b0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (keep[k] && (!any_valid ||
                            better(CMP_W'(signed'(data[k*D_W +: D_W])), CMP_W'(win_val), mode))) begin
                win_val   = signed'(data[k*D_W +: D_W]);
                win_lane  = LANE_W'(k);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/row_max_reduce.sv
// Streaming multi-lane row max/min reducer with argmax, element count and
// overflow flag; one registered result per in_last-delimited row.
module row_max_reduce
    import ibert_reduce_pkg::*;
#(
    parameter  int unsigned D_W       = 32,
    parameter  int unsigned LANES     = 4,
    parameter  int unsigned MAX_ELEMS = 1024,
    localparam int unsigned IDX_W     = $clog2(MAX_ELEMS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*D_W-1:0] in_data,
    input  logic [LANES-1:0]     in_keep,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [D_W-1:0]       out_val,
    output logic [IDX_W-1:0]     out_idx,
    output logic [IDX_W:0]       out_count,
    output logic                 out_empty,
    output logic                 out_ovf
);

    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned POS_W  = $clog2(MAX_ELEMS + LANES) + 1;
    localparam int unsigned CNT_W  = IDX_W + 1;
    localparam logic [POS_W-1:0]      MAX_POS = POS_W'(MAX_ELEMS);
    localparam logic signed [D_W-1:0] NEG_VAL = D_W'(sat_neg(D_W));
    localparam logic signed [D_W-1:0] POS_VAL = D_W'(sat_pos(D_W));

    state_e                 state;
    reduce_mode_e           row_mode;
    logic [POS_W-1:0]       base_pos;
    logic signed [D_W-1:0]  acc_val;
    logic signed [D_W-1:0]  acc_ival;
    logic                   acc_found;
    logic                   acc_ifound;
    logic [IDX_W-1:0]       acc_idx;
    logic [CNT_W-1:0]       acc_count;
    logic                   acc_ovf;

    logic                   first;
    logic                   accept;
    reduce_mode_e           eff_mode;
    logic [POS_W-1:0]       cur_base;
    logic [LANES-1:0]       range_keep;
    logic                   beat_ovf;
    logic [POS_W-1:0]       keep_cnt;
    logic [POS_W-1:0]       cnt_sum;

    logic signed [D_W-1:0]  all_val;
    logic [LANE_W-1:0]      all_lane;
    logic                   all_any;
    logic signed [D_W-1:0]  rng_val;
    logic [LANE_W-1:0]      rng_lane;
    logic                   rng_any;

    logic signed [D_W-1:0]  p_val, p_ival, nxt_val, nxt_ival;
    logic                   p_found, p_ifound, nxt_found, nxt_ifound;
    logic [IDX_W-1:0]       p_idx, nxt_idx;
    logic [CNT_W-1:0]       p_count, nxt_count;
    logic                   nxt_ovf;
    logic [POS_W-1:0]       nxt_base;

    assign first    = (state == S_IDLE);
    assign accept   = in_valid & in_ready;
    assign eff_mode = first ? reduce_mode_e'(mode) : row_mode;
    assign cur_base = first ? '0 : base_pos;

    always_comb begin
        range_keep = '0;
        keep_cnt   = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            range_keep[k] = in_keep[k] && ((cur_base + POS_W'(k)) < MAX_POS);
            keep_cnt      = keep_cnt + POS_W'(in_keep[k]);
        end
        beat_ovf = |(in_keep & ~range_keep);
    end

    // Value tracks every kept element; the index only follows in-range elements
    // so it stays at the last in-range winner once positions run past MAX_ELEMS.
    lane_max_tree #(.D_W(D_W), .LANES(LANES)) u_all_tree (
        .data      (in_data),
        .keep      (in_keep),
        .mode      (eff_mode),
        .win_val   (all_val),
        .win_lane  (all_lane),
        .any_valid (all_any)
    );

    lane_max_tree #(.D_W(D_W), .LANES(LANES)) u_range_tree (
        .data      (in_data),
        .keep      (range_keep),
        .mode      (eff_mode),
        .win_val   (rng_val),
        .win_lane  (rng_lane),
        .any_valid (rng_any)
    );

    always_comb begin
        p_val     = first ? ((eff_mode == RED_MAX) ? NEG_VAL : POS_VAL) : acc_val;
        p_found   = first ? 1'b0 : acc_found;
        p_ival    = first ? '0 : acc_ival;
        p_ifound  = first ? 1'b0 : acc_ifound;
        p_idx     = first ? '0 : acc_idx;
        p_count   = first ? '0 : acc_count;

        nxt_val   = p_val;
        nxt_found = p_found | all_any;
        if (all_any && (!p_found || better(CMP_W'(all_val), CMP_W'(p_val), eff_mode)))
            nxt_val = all_val;

        nxt_ival   = p_ival;
        nxt_idx    = p_idx;
        nxt_ifound = p_ifound | rng_any;
        if (rng_any && (!p_ifound || better(CMP_W'(rng_val), CMP_W'(p_ival), eff_mode))) begin
            nxt_ival = rng_val;
            nxt_idx  = IDX_W'(cur_base + POS_W'(rng_lane));
        end

        cnt_sum   = POS_W'(p_count) + keep_cnt;
        nxt_count = (cnt_sum > MAX_POS) ? CNT_W'(MAX_ELEMS) : CNT_W'(cnt_sum);
        nxt_ovf   = (first ? 1'b0 : acc_ovf) | beat_ovf;
        nxt_base  = ((cur_base + POS_W'(LANES)) >= MAX_POS) ? MAX_POS : cur_base + POS_W'(LANES);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            row_mode   <= RED_MAX;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_val    <= '0;
            out_idx    <= '0;
            out_count  <= '0;
            out_empty  <= 1'b0;
            out_ovf    <= 1'b0;
            base_pos   <= '0;
            acc_val    <= '0;
            acc_ival   <= '0;
            acc_found  <= 1'b0;
            acc_ifound <= 1'b0;
            acc_idx    <= '0;
            acc_count  <= '0;
            acc_ovf    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_ACCUM: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        if (first)
                            row_mode <= reduce_mode_e'(mode);
                        base_pos   <= nxt_base;
                        acc_val    <= nxt_val;
                        acc_ival   <= nxt_ival;
                        acc_found  <= nxt_found;
                        acc_ifound <= nxt_ifound;
                        acc_idx    <= nxt_idx;
                        acc_count  <= nxt_count;
                        acc_ovf    <= nxt_ovf;
                        if (in_last) begin
                            state     <= S_HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_val   <= nxt_val;
                            out_idx   <= nxt_idx;
                            out_count <= nxt_count;
                            out_empty <= !nxt_found;
                            out_ovf   <= nxt_ovf;
                        end else begin
                            state <= S_ACCUM;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_row_max_reduce.sv
// Bench for row_max_reduce: directed rows plus random rows against an
// element-level reference, on a default instance and a MAX_ELEMS=8 instance.
module tb_row_max_reduce;

    localparam int D_W   = 32;
    localparam int LANES = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 mode;
    logic                 in_valid;
    logic [LANES*D_W-1:0] in_data;
    logic [LANES-1:0]     in_keep;
    logic                 in_last;
    logic                 out_ready;

    logic                 in_ready, out_valid, out_empty, out_ovf;
    logic [D_W-1:0]       out_val;
    logic [9:0]           out_idx;
    logic [10:0]          out_count;

    logic                 in_ready8, out_valid8, out_empty8, out_ovf8;
    logic [D_W-1:0]       out_val8;
    logic [2:0]           out_idx8;
    logic [3:0]           out_count8;

    int n_assert = 0;
    int n_fail   = 0;

    logic [LANES*D_W-1:0] bd [8];
    logic [LANES-1:0]     bk [8];
    int                   nb;
    bit                   rmode;

    row_max_reduce dut (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_keep(in_keep), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_val(out_val), .out_idx(out_idx), .out_count(out_count),
        .out_empty(out_empty), .out_ovf(out_ovf)
    );

    row_max_reduce #(.MAX_ELEMS(8)) dut8 (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready8),
        .in_data(in_data), .in_keep(in_keep), .in_last(in_last), .out_valid(out_valid8),
        .out_ready(out_ready), .out_val(out_val8), .out_idx(out_idx8), .out_count(out_count8),
        .out_empty(out_empty8), .out_ovf(out_ovf8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: scan the row element by element in index order.
    task automatic model(input int maxe, output logic [31:0] e_val, output int e_idx,
                         output int e_cnt, output bit e_empty, output bit e_ovf);
        logic signed [31:0] v, best, ibest;
        bit found, ifound;
        best = 0; ibest = 0; found = 0; ifound = 0;
        e_idx = 0; e_cnt = 0; e_ovf = 0;
        for (int p = 0; p < nb * LANES; p++) begin
            if (bk[p / LANES][p % LANES]) begin
                v = bd[p / LANES][(p % LANES) * D_W +: D_W];
                e_cnt++;
                if (p >= maxe) e_ovf = 1;
                if (!found || (rmode ? (v < best) : (v > best))) begin
                    best = v; found = 1;
                end
                if (p < maxe && (!ifound || (rmode ? (v < ibest) : (v > ibest)))) begin
                    ibest = v; ifound = 1; e_idx = p;
                end
            end
        end
        e_val   = found ? best : (rmode ? 32'h7fff_ffff : 32'h8000_0000);
        e_empty = (e_cnt == 0);
        if (e_cnt > maxe) e_cnt = maxe;
    endtask

    task automatic expect_row(input string tag);
        logic [31:0] ev; int ei, ec; bit ee, eo;
        model(1024, ev, ei, ec, ee, eo);
        chk({tag, "/valid"}, 64'(out_valid), 64'(1));
        chk({tag, "/val"},   64'(out_val),   64'(ev));
        chk({tag, "/idx"},   64'(out_idx),   64'(ei));
        chk({tag, "/count"}, 64'(out_count), 64'(ec));
        chk({tag, "/empty"}, 64'(out_empty), 64'(ee));
        chk({tag, "/ovf"},   64'(out_ovf),   64'(eo));
        model(8, ev, ei, ec, ee, eo);
        chk({tag, "/valid8"}, 64'(out_valid8), 64'(1));
        chk({tag, "/val8"},   64'(out_val8),   64'(ev));
        chk({tag, "/idx8"},   64'(out_idx8),   64'(ei));
        chk({tag, "/count8"}, 64'(out_count8), 64'(ec));
        chk({tag, "/empty8"}, 64'(out_empty8), 64'(ee));
        chk({tag, "/ovf8"},   64'(out_ovf8),   64'(eo));
    endtask

    // Called on a negedge; returns on the negedge after the beat is accepted.
    task automatic send_beat(input logic [LANES*D_W-1:0] d, input logic [LANES-1:0] k,
                             input bit last, input bit m);
        int w = 0;
        in_valid = 1'b1; in_data = d; in_keep = k; in_last = last; mode = m;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("accept_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Non-first beats drive the opposite mode, which must be ignored.
    task automatic send_row(input string tag);
        for (int b = 0; b < nb; b++)
            send_beat(bd[b], bk[b], b == nb - 1, (b == 0) ? rmode : ~rmode);
        chk({tag, "/latency"}, 64'(out_valid), 64'(1));
    endtask

    task automatic consume(input int d);
        for (int i = 0; i < d; i++) begin
            @(negedge clk);
            chk("hold_ready", 64'(in_ready), 64'(0));
            chk("hold_valid", 64'(out_valid), 64'(1));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_valid", 64'(out_valid), 64'(0));
        chk("release_ready", 64'(in_ready), 64'(1));
    endtask

    task automatic set_beat(input int b, input int e0, input int e1, input int e2, input int e3,
                            input logic [3:0] k);
        bd[b] = {32'(e3), 32'(e2), 32'(e1), 32'(e0)};
        bk[b] = k;
    endtask

    initial begin
        logic [31:0] hold_val;
        logic [31:0] v;
        rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = '0; in_keep = '0;
        in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst/in_ready",  64'(in_ready),  64'(0));
        chk("rst/out_valid", 64'(out_valid), 64'(0));
        chk("rst/out_val",   64'(out_val),   64'(0));
        chk("rst/out_idx",   64'(out_idx),   64'(0));
        chk("rst/out_count", 64'(out_count), 64'(0));
        chk("rst/out_empty", 64'(out_empty), 64'(0));
        chk("rst/out_ovf",   64'(out_ovf),   64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst/in_ready", 64'(in_ready), 64'(1));

        // Basic max, single beat, tie between lanes 2 and 3
        nb = 1; rmode = 0; set_beat(0, 5, -3, 9, 9, 4'b1111);
        send_row("basic"); expect_row("basic"); consume(0);

        // Min mode, cross-beat handling
        nb = 2; rmode = 1; set_beat(0, 7, 2, 8, 4, 4'b1111); set_beat(1, 2, 1, 3, 6, 4'b1111);
        send_row("min"); expect_row("min"); consume(1);
        set_beat(1, 2, 3, 3, 6, 4'b1111);
        send_row("min_tie"); expect_row("min_tie"); consume(0);

        // Masked lanes, then empty rows in both modes
        nb = 1; rmode = 0; set_beat(0, 50, 60, -20, 70, 4'b0100);
        send_row("mask"); expect_row("mask"); consume(0);
        set_beat(0, 1, 2, 3, 4, 4'b0000);
        send_row("empty_max"); expect_row("empty_max"); consume(0);
        rmode = 1;
        send_row("empty_min"); expect_row("empty_min"); consume(0);

        // Backpressure with the next row waiting
        nb = 1; rmode = 0; set_beat(0, -1, 40, 40, 3, 4'b1111);
        send_row("bp1"); expect_row("bp1");
        hold_val = out_val;
        set_beat(0, 11, 12, -13, 10, 4'b1011); rmode = 1;
        in_valid = 1'b1; in_data = bd[0]; in_keep = bk[0]; in_last = 1'b1; mode = rmode;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp/in_ready", 64'(in_ready), 64'(0));
            chk("bp/out_val",  64'(out_val),  64'(hold_val));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp/ready_after", 64'(in_ready), 64'(1));
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        chk("bp2/latency", 64'(out_valid), 64'(1));
        expect_row("bp2"); consume(0);

        // Overflow on the MAX_ELEMS=8 instance: peak lands in beat 3
        nb = 3; rmode = 0;
        set_beat(0, 1, 2, 3, 4, 4'b1111); set_beat(1, 5, 6, 7, 8, 4'b1111);
        set_beat(2, 1, 50, 2, 3, 4'b1111);
        send_row("ovf"); expect_row("ovf"); consume(0);

        // Reset in the middle of a row
        send_beat({4{32'd100}}, 4'b1111, 1'b0, 1'b0);
        send_beat({4{32'd100}}, 4'b1111, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst/in_ready",  64'(in_ready),  64'(0));
        chk("midrst/out_valid", 64'(out_valid), 64'(0));
        chk("midrst/out_val",   64'(out_val),   64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("midrst/ready_after", 64'(in_ready), 64'(1));
        nb = 1; rmode = 0; set_beat(0, 1, 2, 3, 4, 4'b1111);
        send_row("rowB"); expect_row("rowB"); consume(0);

        // Random rows: small value range to force ties, random masks and modes
        for (int r = 0; r < 40; r++) begin
            nb = $urandom_range(1, 6);
            rmode = 1'($urandom_range(0, 1));
            for (int b = 0; b < nb; b++) begin
                for (int k = 0; k < LANES; k++) begin
                    if ($urandom_range(0, 3) == 0) v = $urandom;
                    else v = 32'($urandom_range(0, 16)) - 32'd8;
                    bd[b][k*D_W +: D_W] = v;
                end
                bk[b] = ($urandom_range(0, 3) == 0) ? 4'b1111 : 4'($urandom_range(0, 15));
            end
            send_row("rand");
            expect_row("rand");
            consume($urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/row_max_reduce.md
# row_max_reduce

Streaming multi-lane row maximum/minimum reducer with argmax tracking, used ahead of the softmax exponent stage to find the per-row peak of signed attention scores. It accepts `LANES` elements per beat over a valid/ready handshake, reduces a whole row delimited by `in_last`, and presents one registered result per row (value, element index, element count, flags) over a second valid/ready handshake. It supersedes the single-element, externally-enabled running max.

## Interface
- `D_W`, 32, signed element width
- `LANES`, 4, elements per input beat (≥1)
- `MAX_ELEMS`, 1024, largest row length whose index and count are exact
- `IDX_W`, `$clog2(MAX_ELEMS)`, derived width of `out_idx`. Not overridable.

- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `mode`  in  1  0 = max, 1 = min; sampled on the first accepted beat of a row
- `in_valid`  in  1  beat valid
- `in_ready`  out  1  beat accepted when `in_valid & in_ready`
- `in_data`  in  `LANES*D_W`  lane k at bits `[k*D_W +: D_W]`, signed
- `in_keep`  in  `LANES`  per-lane element-present mask
- `in_last`  in  1  final beat of the row
- `out_valid`  out  1  result valid
- `out_ready`  in  1  result consumed when `out_valid & out_ready`
- `out_val`  out  `D_W`  row max (or min)
- `out_idx`  out  `IDX_W`  index of the winning element
- `out_count`  out  `IDX_W+1`  number of kept elements in the row
- `out_empty`  out  1  row had no kept elements
- `out_ovf`  out  1  row exceeded `MAX_ELEMS` positions

## Operation
- FSM states:
  - **IDLE**: `in_ready=1`. An accepted beat loads the accumulator from that beat's lane result and goes to ACCUM. If `in_last` is set on that beat, it goes straight to HOLD.
  - **ACCUM**: `in_ready=1`. Each accepted beat is folded into the accumulator. An accepted beat with `in_last` goes to HOLD.
  - **HOLD**: `in_ready=0`, `out_valid=1`, outputs stable. `out_ready` returns the FSM to IDLE.
- Element index: `beat_cnt*LANES + k`. Beats with `in_keep=0` still advance `beat_cnt`.
- Compare is signed. Ties go to the lowest index, both within a beat (lowest lane) and across beats (an earlier element wins on equality).
- Masked lanes never win.
- Empty row (no kept lanes):
  - `out_val` = most-negative value in max mode, most-positive in min mode.
  - `out_idx=0`, `out_count=0`, `out_empty=1`.
- Overflow: an element position ≥ `MAX_ELEMS` sets the sticky `out_ovf`. From then on `out_idx` is frozen, `out_count` saturates at `MAX_ELEMS`, and value tracking continues.
- `mode` changes mid-row are ignored until the next row.
- Reset mid-row discards all partial state and returns the FSM to IDLE.

## Timing
- Reset values: `in_ready=0` during reset and 1 in the cycle after reset deasserts; `out_valid=0`; `out_val=0`; `out_idx=0`; `out_count=0`; `out_empty=0`; `out_ovf=0`.
- Latency: `out_valid` rises one cycle after the `in_last` beat is accepted.
- Throughput: one beat per cycle within a row. Minimum one `in_ready=0` cycle per row (HOLD), longer under `out_ready` backpressure.
- `out_*` change only on the IDLE/ACCUM→HOLD transition; they hold through HOLD and until the next row completes.
- Single-beat row: accepted in IDLE, result valid the next cycle.
- A reset asserted in the same cycle as an accepted `in_last`, or in the same cycle as `out_ready` in HOLD: reset wins.

## Structure
- Package `ibert_reduce_pkg`:
  - `reduce_mode_e` (`RED_MAX`, `RED_MIN`)
  - `state_e` (`S_IDLE`, `S_ACCUM`, `S_HOLD`)
  - functions `sat_neg(D_W)` / `sat_pos(D_W)`
  - compare helper `better(a, b, mode)`, a strict inequality so ties keep the earlier element
- One sub-module, `lane_max_tree`: a combinational `LANES`-input compare tree with mask and mode. It outputs the winning value, its lane index and an any-valid flag, honouring lowest-lane tie-break.
- The top module holds the FSM, beat counter, accumulator, count/ovf logic and output registers.

## Test plan
- **Basic max**: `LANES=4`, one beat of {5, -3, 9, 9}, last, max mode → `out_val=9`, `out_idx=2`, `out_count=4`, `out_valid` one cycle after accept.
- **Multi-beat, min mode, cross-beat tie**: beats {7, 2, 8, 4} then {2, 1, 3, 6}, last → `out_val=1`, `out_idx=5`. Repeat with the second beat changed to {2, 3, 3, 6} → `out_val=2`, `out_idx=1`.
- **Masks and empty row**: first row, `keep=4'b0100` with lane 2 = -20 → `out_idx=2`, `out_count=1`. Then an all-zero-keep row in max mode → `out_val=32'h8000_0000`, `out_empty=1`.
- **Backpressure**: hold `out_ready=0` for 5 cycles with the next row pending → `in_ready=0` and outputs stable throughout; the next row is accepted the cycle after `out_ready=1`.
- **Overflow**: `MAX_ELEMS=8`, `LANES=4`, three beats whose max is in beat 3 → `out_ovf=1`, `out_count=8`, `out_val` correct, `out_idx` equal to the last in-range winner.
- **Reset mid-row**: two beats of row A (max 100), `rst` for one cycle, then row B {1, 2, 3, 4}, last → `out_val=4`, `out_idx=3`, with no trace of row A.
